// File: rtl/dqs_trim_seq_if.sv
// Bus between the CPU trim register / DQS delay block and the trim sequencer.
// Every signal is a plain level, sampled on the rising edge of clk. start is
// a request qualified only by itself: it is acted on when high for one rising
// edge while the sequencer is idle, and is otherwise dropped.
interface dqs_trim_seq_if #(
    parameter int TO_W = 12
);
    logic            start;
    logic [3:0]      FreqSel;
    logic            trim_done;
    logic [6:0]      trim_cnt;
    logic [4:0]      offset;
    logic [TO_W-1:0] timeout;
    logic [7:0]      Fm_dly_control;
    logic [6:0]      dly_adj;
    logic            dly_adj_en;
    logic            busy;
    logic            done_pulse;
    logic            err_timeout;
    logic [6:0]      trim_val;
    logic [2:0]      state_dbg;

    // Driver side: CPU register plus the DQS delay block.
    modport master (
        output start, FreqSel, trim_done, trim_cnt, offset, timeout,
        input  Fm_dly_control, dly_adj, dly_adj_en, busy, done_pulse,
               err_timeout, trim_val, state_dbg
    );

    // Sequencer side.
    modport slave (
        input  start, FreqSel, trim_done, trim_cnt, offset, timeout,
        output Fm_dly_control, dly_adj, dly_adj_en, busy, done_pulse,
               err_timeout, trim_val, state_dbg
    );
endinterface

// File: rtl/dqs_trim_seq.sv
// DQS delay trim sequencer: resets the autotrim logic, waits for a qualified
// trim_done, captures the tap count, applies an offset-adjusted manual tap and
// lets the delay line settle. Retriggers on start or a FreqSel change.
module dqs_trim_seq #(
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 8,
    parameter int TO_W       = 12
) (
    input logic         clk,
    input logic         RST_n,
    dqs_trim_seq_if.slave bus
);

    // One shared phase counter covers RESET, TRACK and APPLY, so it must be
    // wide enough for the largest of the three.
    localparam int PH_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int CNT_W  = (TO_W > PH_W) ? TO_W : PH_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_TRACK   = 3'd2,
        S_CAPTURE = 3'd3,
        S_APPLY   = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             td_q;
    logic [3:0]       fs_saved;
    logic             ctrl_rst;
    logic             ctrl_sel;
    logic [6:0]       adj_r;
    logic             adj_en_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [6:0]       trim_val_r;

    logic signed [7:0] adj_sum;
    logic [6:0]        adj_clamped;
    logic              to_en;
    logic [CNT_W-1:0]  to_last;

    // Offset-adjusted tap: 8-bit signed sum, clamped to the legal 0..64 range.
    always_comb begin
        adj_sum = $signed({1'b0, bus.trim_cnt}) + $signed({{3{bus.offset[4]}}, bus.offset});
        if (adj_sum < 8'sd0) begin
            adj_clamped = 7'd0;
        end else if (adj_sum > 8'sd64) begin
            adj_clamped = 7'd64;
        end else begin
            adj_clamped = adj_sum[6:0];
        end
    end

    // Timeout compare value; a zero timeout disables the expiry path.
    always_comb begin
        to_en   = (bus.timeout != '0);
        to_last = CNT_W'(bus.timeout) - CNT_W'(1);
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            td_q       <= 1'b0;
            fs_saved   <= 4'd0;
            ctrl_rst   <= 1'b0;
            ctrl_sel   <= 1'b0;
            adj_r      <= 7'd0;
            adj_en_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            trim_val_r <= 7'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start || (bus.FreqSel != fs_saved)) begin
                        state    <= S_RESET;
                        fs_saved <= bus.FreqSel;
                        err_r    <= 1'b0;
                        adj_en_r <= 1'b0;
                        ctrl_sel <= 1'b0;
                        ctrl_rst <= 1'b1;
                        busy_r   <= 1'b1;
                        cnt      <= '0;
                        td_q     <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (cnt == CNT_W'(RST_CYC - 1)) begin
                        state    <= S_TRACK;
                        ctrl_rst <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_TRACK: begin
                    td_q <= bus.trim_done;
                    // Qualification is checked first so it wins a tie with expiry.
                    if (bus.trim_done && td_q) begin
                        state <= S_CAPTURE;
                    end else if (to_en && (cnt == to_last)) begin
                        state    <= S_ERR;
                        err_r    <= 1'b1;
                        adj_en_r <= 1'b0;
                        ctrl_sel <= 1'b0;
                        ctrl_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    trim_val_r <= bus.trim_cnt;
                    adj_r      <= adj_clamped;
                    adj_en_r   <= 1'b1;
                    ctrl_sel   <= 1'b1;
                    cnt        <= '0;
                    state      <= S_APPLY;
                end
                S_APPLY: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ERR: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    cnt    <= '0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Fm_dly_control = {6'b000000, ctrl_sel, ctrl_rst};
    assign bus.dly_adj        = adj_r;
    assign bus.dly_adj_en     = adj_en_r;
    assign bus.busy           = busy_r;
    assign bus.done_pulse     = done_r;
    assign bus.err_timeout    = err_r;
    assign bus.trim_val       = trim_val_r;
    assign bus.state_dbg      = state;

endmodule

// File: tb/tb_dqs_trim_seq.sv
// Directed + randomized bench for the DQS trim sequencer.
module tb_dqs_trim_seq;

    localparam int RST_CYC    = 4;
    localparam int SETTLE_CYC = 8;
    localparam int TO_W       = 12;
    localparam int BUDGET     = 2000;

    logic clk;
    logic RST_n;

    dqs_trim_seq_if #(.TO_W(TO_W)) bus ();

    dqs_trim_seq #(
        .RST_CYC(RST_CYC),
        .SETTLE_CYC(SETTLE_CYC),
        .TO_W(TO_W)
    ) dut (
        .clk(clk),
        .RST_n(RST_n),
        .bus(bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [6:0] exp_q[$];

    // Observations collected by run_trim
    int r_rst, r_track, r_apply, r_done, r_err, r_err0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference tap: signed sum, clamped to 0..64.
    function automatic int adj_ref(input int tc, input int off);
        int s;
        s = tc + off;
        if (s < 0) return 0;
        if (s > 64) return 64;
        return s;
    endfunction

    // Drives one trim (optionally started by start) and observes it per cycle.
    // Sample index c counts falling edges after the triggering rising edge.
    task automatic run_trim(input bit do_start, input int td_on, input int glitch_at,
                            input int fs_at, input logic [3:0] fs_val, input int start_at);
        r_rst = 0; r_track = 0; r_apply = 0; r_done = 0; r_err = 0; r_err0 = -1;
        bus.trim_done = 1'b0;
        if (do_start) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            if (c == 0) r_err0 = int'(bus.err_timeout);
            if (bus.done_pulse) begin r_done = 1; break; end
            if (!bus.busy) break;
            if (bus.Fm_dly_control[0]) r_rst++;
            if (!bus.Fm_dly_control[0] && !bus.dly_adj_en && !bus.err_timeout) r_track++;
            if (bus.dly_adj_en) r_apply++;
            if (bus.err_timeout) r_err = 1;
            bus.start = (c == start_at);
            if (c == glitch_at) bus.trim_done = 1'b1;
            if (c == glitch_at + 1) bus.trim_done = 1'b0;
            if (c == td_on) bus.trim_done = 1'b1;
            if (c == fs_at) bus.FreqSel = fs_val;
            tick();
        end
        bus.start = 1'b0;
        bus.trim_done = 1'b0;
    endtask

    // Successful trim with scoreboard compare of the applied tap.
    task automatic trim_ok(input string tag, input int tc, input int off, input int td_on);
        bus.trim_cnt = 7'(tc);
        bus.offset   = 5'(off);
        exp_q.push_back(7'(adj_ref(tc, off)));
        run_trim(1'b1, td_on, -10, -10, 4'd0, -10);
        check({tag, ".done"}, r_done, 1);
        check({tag, ".dly_adj"}, bus.dly_adj, exp_q.pop_front());
        check({tag, ".trim_val"}, bus.trim_val, tc);
        check({tag, ".en"}, bus.dly_adj_en, 1);
        check({tag, ".ctrl"}, bus.Fm_dly_control, 8'h02);
        check({tag, ".settle"}, r_apply, SETTLE_CYC);
    endtask

    initial begin
        RST_n = 1'b0;
        bus.start = 1'b0; bus.FreqSel = 4'd0; bus.trim_done = 1'b0;
        bus.trim_cnt = 7'd0; bus.offset = 5'd0; bus.timeout = '0;
        repeat (3) tick();

        // Reset values
        check("rst.ctrl", bus.Fm_dly_control, 0);
        check("rst.adj", bus.dly_adj, 0);
        check("rst.en", bus.dly_adj_en, 0);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done_pulse, 0);
        check("rst.err", bus.err_timeout, 0);
        check("rst.trim_val", bus.trim_val, 0);
        RST_n = 1'b1;
        repeat (2) tick();
        check("idle.busy", bus.busy, 0);

        // Basic trim: trim_cnt=20, offset=+3, trim_done from cycle 10
        trim_ok("basic", 20, 3, 10);
        check("basic.rst_cyc", r_rst, RST_CYC);
        check("basic.err", r_err, 0);
        repeat (3) tick();
        check("hold.en", bus.dly_adj_en, 1);
        check("hold.adj", bus.dly_adj, 23);
        check("hold.ctrl", bus.Fm_dly_control, 8'h02);

        // Clamp limits
        trim_ok("clamp_hi", 62, 15, 6);
        trim_ok("clamp_lo", 5, -16, 7);

        // Randomized trims
        for (int i = 0; i < 6; i++) begin
            trim_ok("rand", int'($urandom_range(0, 112)), int'($urandom_range(0, 31)) - 16,
                    int'($urandom_range(RST_CYC, 30)));
        end

        // Timeout of 100 with trim_done held low
        bus.timeout = TO_W'(100);
        run_trim(1'b1, -10, -10, -10, 4'd0, -10);
        check("to100.err", bus.err_timeout, 1);
        check("to100.track", r_track, 100);
        check("to100.done", r_done, 0);
        check("to100.ctrl", bus.Fm_dly_control, 0);
        check("to100.en", bus.dly_adj_en, 0);
        repeat (3) tick();
        check("to100.sticky", bus.err_timeout, 1);
        run_trim(1'b1, 8, -10, -10, 4'd0, -10);
        check("to100.clear", r_err0, 0);
        check("to100.retrim", r_done, 1);

        // Timeout boundaries: timeout=1, and qualification tying with expiry
        bus.timeout = TO_W'(1);
        run_trim(1'b1, -10, -10, -10, 4'd0, -10);
        check("to1.track", r_track, 1);
        check("to1.err", bus.err_timeout, 1);
        bus.timeout = TO_W'(20);
        run_trim(1'b1, 22, -10, -10, 4'd0, -10);
        check("tie.done", r_done, 1);
        check("tie.err", r_err, 0);
        run_trim(1'b1, 23, -10, -10, 4'd0, -10);
        check("late.done", r_done, 0);
        check("late.track", r_track, 20);
        bus.timeout = '0;

        // Glitch rejection; start during busy is ignored
        bus.trim_cnt = 7'd40; bus.offset = 5'd0;
        run_trim(1'b1, 15, 8, -10, 4'd0, 10);
        check("glitch.track", r_track, 15 - RST_CYC + 3);
        check("glitch.done", r_done, 1);
        tick();
        check("busy_start.ignored", bus.busy, 0);

        // FreqSel change in IDLE triggers a trim without start
        bus.FreqSel = 4'd3;
        run_trim(1'b0, 8, -10, -10, 4'd0, -10);
        check("fs_idle.rst", r_rst, RST_CYC);
        check("fs_idle.done", r_done, 1);
        // FreqSel change during TRACK: second trim follows at once
        run_trim(1'b1, 12, -10, 6, 4'd9, -10);
        check("fs_track.first", r_done, 1);
        run_trim(1'b0, 8, -10, -10, 4'd0, -10);
        check("fs_track.second_rst", r_rst, RST_CYC);
        check("fs_track.second_done", r_done, 1);
        repeat (3) tick();
        check("fs_track.settled", bus.busy, 0);

        // Reset during APPLY aborts immediately
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        r_done = 0;
        for (int c = 0; c < 200; c++) begin
            if (bus.dly_adj_en && bus.busy) break;
            if (bus.done_pulse) r_done = 1;
            if (c == 8) bus.trim_done = 1'b1;
            tick();
        end
        check("abort.in_apply", bus.dly_adj_en, 1);
        #2 RST_n = 1'b0;
        #1;
        check("abort.ctrl", bus.Fm_dly_control, 0);
        check("abort.adj", bus.dly_adj, 0);
        check("abort.en", bus.dly_adj_en, 0);
        check("abort.busy", bus.busy, 0);
        check("abort.trim_val", bus.trim_val, 0);
        bus.trim_done = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.done_pulse) r_done = 1;
        end
        check("abort.no_done", r_done, 0);

        // Release with FreqSel=9 against a cleared saved copy: auto trim
        RST_n = 1'b1;
        run_trim(1'b0, 8, -10, -10, 4'd0, -10);
        check("auto.rst", r_rst, RST_CYC);
        check("auto.done", r_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dqs_trim_seq.md
DQS_TRIM_SEQ -- requirements
Module: dqs_trim_seq

Interface
REQ-001 The parameter RST_CYC SHALL default to 4 and set the number of cycles autotrim reset is held.
REQ-002 The parameter SETTLE_CYC SHALL default to 8 and set the cycles waited after the manual adjust is applied.
REQ-003 The parameter TO_W SHALL default to 12 and set the width of the timeout counter.
REQ-004 clk  in  1  FmClk, the only clock; every flop SHALL be on its rising edge.
REQ-005 RST_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  single-cycle trim request from the CPU register.
REQ-007 FreqSel  in  4  flash speed select, quasi-static, already synchronized to clk.
REQ-008 trim_done  in  1  autotrim-done flag from the DQS delay block.
REQ-009 trim_cnt  in  7  auto delay tap count (dly_count_adj) from the DQS delay block.
REQ-010 offset  in  5  signed two's-complement tap offset, -16..+15.
REQ-011 timeout  in  TO_W  maximum cycles allowed in TRACK; 0 means the timeout is disabled.
REQ-012 Fm_dly_control  out  8  [0] autotrim reset, [1] delay-line select, [7:2] SHALL be 0.
REQ-013 dly_adj  out  7  manual tap value for the delay block.
REQ-014 dly_adj_en  out  1  manual tap enable.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 done_pulse  out  1  one-cycle pulse when a trim completes.
REQ-017 err_timeout  out  1  sticky timeout flag.
REQ-018 trim_val  out  7  captured raw trim_cnt, for CPU readback.

Function
REQ-019 The FSM SHALL have the states IDLE, RESET, TRACK, CAPTURE, APPLY and ERR.
REQ-020 In IDLE, a start pulse or a change in FreqSel since the last trim (held in a registered copy) SHALL move the FSM to RESET on the next edge.
REQ-021 The FSM SHALL sample and save FreqSel on that transition.
REQ-022 On entry to RESET, the block SHALL clear err_timeout and dly_adj_en and set Fm_dly_control[1]=0.
REQ-023 RESET SHALL drive Fm_dly_control[0]=1 for exactly RST_CYC cycles, then go to TRACK.
REQ-024 TRACK SHALL move to CAPTURE after trim_done has been sampled high on 2 consecutive cycles.
REQ-025 A single-cycle trim_done glitch SHALL reset the qualification.
REQ-026 In TRACK, when timeout!=0, a counter SHALL run; on reaching timeout-1 without qualification, the FSM SHALL go to ERR.
REQ-027 If qualification and expiry occur in the same cycle, qualification SHALL win.
REQ-028 CAPTURE SHALL last 1 cycle and SHALL latch trim_val<=trim_cnt.
REQ-029 In CAPTURE, dly_adj SHALL be loaded with clamp(trim_cnt + sign-extended offset, 0, 64), computed at 8-bit signed width.
REQ-030 APPLY SHALL assert dly_adj_en=1 and Fm_dly_control[1]=1, wait SETTLE_CYC cycles, then pulse done_pulse for 1 cycle and return to IDLE.
REQ-031 dly_adj_en, dly_adj and Fm_dly_control[1] SHALL hold their APPLY values in IDLE until the next RESET entry.
REQ-032 ERR SHALL set err_timeout=1 and drive dly_adj_en=0, Fm_dly_control[1]=0 (bypass) and Fm_dly_control[0]=0.
REQ-033 ERR SHALL return to IDLE after 1 cycle, with no done_pulse.
REQ-034 start or a FreqSel change while busy=1 SHALL be ignored, except that a FreqSel change SHALL still trigger a new trim from IDLE afterwards, because the saved copy differs.
REQ-035 err_timeout SHALL stay set through IDLE until the next RESET entry.
REQ-036 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-037 While RST_n=0, the block SHALL force: state IDLE, Fm_dly_control=8'h00, dly_adj=0, dly_adj_en=0, busy=0, done_pulse=0, err_timeout=0, trim_val=0, saved FreqSel=0, and all counters to 0.
REQ-038 Reset asserted mid-trim SHALL abort immediately with no done_pulse.
REQ-039 After reset, a nonzero FreqSel SHALL trigger a trim automatically on the first cycle after reset release.

Verification
REQ-040 Scenario: start; trim_done high from cycle 10; trim_cnt=20; offset=+3 -> Fm_dly_control[0] high for 4 cycles, dly_adj=23, dly_adj_en=1, done_pulse 8 cycles after APPLY entry, trim_val=20.
REQ-041 Scenario: clamp limits; trim_cnt=62 with offset=+15, and trim_cnt=5 with offset=-16 -> dly_adj=64 and dly_adj=0 respectively.
REQ-042 Scenario: timeout=100; trim_done held low -> err_timeout=1 after 100 TRACK cycles, Fm_dly_control[1]=0, no done_pulse; next start clears err_timeout.
REQ-043 Scenario: FreqSel 0->3 while IDLE -> RESET entered without start; FreqSel change during TRACK -> second trim runs right after the first done_pulse.
REQ-044 Scenario: 1-cycle trim_done glitch in TRACK -> no CAPTURE; sustained trim_done -> CAPTURE.
REQ-045 Scenario: RST_n low during APPLY -> all outputs at reset values immediately; no done_pulse.
